// File: rtl/frame_snap_ctrl.sv
`default_nettype none
// ============================================================================
// frame_snap_ctrl : freezes one camera frame and streams it to the OLED block
// Revision 1.0 : initial release
// ============================================================================
module frame_snap_ctrl #(
   parameter int C_IMG_COLS    = 80,
   parameter int C_IMG_ROWS    = 60,
   parameter int C_NB_ADDR     = 13,
   parameter int C_NB_PXL      = 16,
   parameter int C_AUTO_PERIOD = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 snap_req,
   input  logic                 btn_hold,
   input  logic                 cap_we_in,
   input  logic [C_NB_ADDR-1:0] cap_addr,
   output logic                 cap_we_out,
   input  logic [C_NB_ADDR-1:0] vga_addr,
   output logic [C_NB_ADDR-1:0] rd_addr,
   input  logic [C_NB_PXL-1:0]  rd_data,
   output logic                 vga_blank,
   output logic [C_NB_PXL-1:0]  pix_data,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 oled_rst,
   output logic                 busy,
   output logic [7:0]           frames_sent
);

   localparam int                   C_PXLS     = C_IMG_COLS * C_IMG_ROWS;
   localparam logic [C_NB_ADDR-1:0] C_LAST     = C_NB_ADDR'(C_PXLS - 1);
   localparam logic [7:0]           C_AUTO_CNT = 8'(C_AUTO_PERIOD);
   localparam logic                 C_AUTO_EN  = (C_AUTO_PERIOD != 0);

   localparam logic [2:0] C_S_LIVE  = 3'd0;
   localparam logic [2:0] C_S_ARM   = 3'd1;
   localparam logic [2:0] C_S_ISSUE = 3'd2;
   localparam logic [2:0] C_S_LATCH = 3'd3;
   localparam logic [2:0] C_S_HOLD  = 3'd4;
   localparam logic [2:0] C_S_DONE  = 3'd5;

   logic [2:0]           r_state;
   logic [2:0]           w_next_state;
   logic [C_NB_ADDR-1:0] r_ptr;
   logic [C_NB_PXL-1:0]  r_pix_data;
   logic                 r_pix_valid;
   logic [7:0]           r_frames_sent;
   logic [7:0]           r_auto_cnt;
   logic                 r_snap_q;
   logic                 r_snap_qq;
   logic                 w_eof;
   logic                 w_snap_edge;
   logic                 w_auto_hit;
   logic                 w_trig;

   // EOF uses the raw write enable so btn_hold cannot stall the arm phase
   assign w_eof       = cap_we_in && (cap_addr == C_LAST);
   assign w_snap_edge = r_snap_q & ~r_snap_qq;
   assign w_auto_hit  = C_AUTO_EN && (r_auto_cnt == C_AUTO_CNT);
   assign w_trig      = (r_state == C_S_LIVE) && (w_snap_edge || w_auto_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= C_S_LIVE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         C_S_LIVE:  if (w_trig) w_next_state = C_S_ARM;
         C_S_ARM:   if (w_eof) w_next_state = C_S_ISSUE;
         C_S_ISSUE: w_next_state = C_S_LATCH;
         C_S_LATCH: w_next_state = C_S_HOLD;
         C_S_HOLD:  if (pix_ready) w_next_state = (r_ptr == C_LAST) ? C_S_DONE : C_S_ISSUE;
         C_S_DONE:  w_next_state = C_S_LIVE;
         default:   w_next_state = C_S_LIVE;
      endcase
   end

   always_comb begin
      cap_we_out = 1'b0;
      rd_addr    = vga_addr;
      vga_blank  = 1'b0;
      oled_rst   = 1'b1;
      busy       = (r_state != C_S_LIVE);
      case (r_state)
         C_S_LIVE, C_S_ARM: cap_we_out = cap_we_in & ~btn_hold;
         C_S_DONE:          ;
         default: begin
            rd_addr   = r_ptr;
            vga_blank = 1'b1;
            oled_rst  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr         <= '0;
         r_pix_data    <= '0;
         r_pix_valid   <= 1'b0;
         r_frames_sent <= 8'd0;
         r_auto_cnt    <= 8'd0;
         r_snap_q      <= 1'b0;
         r_snap_qq     <= 1'b0;
      end else begin
         // edge detector keeps tracking the input in every state
         r_snap_q  <= snap_req;
         r_snap_qq <= r_snap_q;
         if (w_trig) begin
            r_auto_cnt <= 8'd0;
         end else if ((r_state == C_S_LIVE) && w_eof) begin
            r_auto_cnt <= r_auto_cnt + 8'd1;
         end
         case (r_state)
            C_S_ARM: begin
               if (w_eof) r_ptr <= '0;
            end
            C_S_LATCH: begin
               r_pix_data  <= rd_data;
               r_pix_valid <= 1'b1;
            end
            C_S_HOLD: begin
               if (pix_ready) begin
                  r_pix_valid <= 1'b0;
                  if (r_ptr != C_LAST) r_ptr <= r_ptr + 1'b1;
               end
            end
            C_S_DONE: r_frames_sent <= r_frames_sent + 8'd1;
            default: ;
         endcase
      end
   end

   assign pix_data    = r_pix_data;
   assign pix_valid   = r_pix_valid;
   assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_frame_snap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frame_snap_ctrl : scoreboard bench for frame_snap_ctrl
// Revision 1.0 : initial release
// ============================================================================
module tb_frame_snap_ctrl;

   localparam int C_PXLS = 4800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        snap_req = 1'b0;
   logic        btn_hold = 1'b0;
   logic        cap_we_in;
   logic [12:0] cap_addr;
   logic [15:0] cap_data;
   logic        cap_we_out;
   logic [12:0] vga_addr = 13'd123;
   logic [12:0] rd_addr;
   logic [15:0] rd_data = 16'd0;
   logic        vga_blank;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        oled_rst;
   logic        busy;
   logic [7:0]  frames_sent;

   logic        a_rst;
   logic        a_cap_we;
   logic [12:0] a_cap_addr;
   logic        a_cap_we_out;
   logic [12:0] a_rd_addr;
   logic        a_vga_blank;
   logic [15:0] a_pix_data;
   logic        a_pix_valid;
   logic        a_oled_rst;
   logic        a_busy;
   logic [7:0]  a_frames_sent;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        cap_run = 1'b0;
   logic [15:0] next_xor = 16'd0;
   logic [15:0] cap_xor = 16'd0;
   logic [12:0] cap_cnt = 13'd0;
   logic        bp_mode = 1'b0;
   logic        ready_level = 1'b0;
   logic        chk_period = 1'b0;
   logic        auto_done = 1'b0;
   logic [15:0] mem [0:C_PXLS-1];
   logic [15:0] exp_q [$];
   logic [12:0] addr_q [$];

   frame_snap_ctrl u_dut (
      .clk(clk), .rst(rst), .snap_req(snap_req), .btn_hold(btn_hold),
      .cap_we_in(cap_we_in), .cap_addr(cap_addr), .cap_we_out(cap_we_out),
      .vga_addr(vga_addr), .rd_addr(rd_addr), .rd_data(rd_data),
      .vga_blank(vga_blank), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .oled_rst(oled_rst), .busy(busy),
      .frames_sent(frames_sent)
   );

   frame_snap_ctrl #(.C_IMG_COLS(8), .C_IMG_ROWS(4), .C_AUTO_PERIOD(3)) u_auto (
      .clk(clk), .rst(a_rst), .snap_req(1'b0), .btn_hold(1'b0),
      .cap_we_in(a_cap_we), .cap_addr(a_cap_addr), .cap_we_out(a_cap_we_out),
      .vga_addr(13'd0), .rd_addr(a_rd_addr), .rd_data(16'h0000),
      .vga_blank(a_vga_blank), .pix_data(a_pix_data), .pix_valid(a_pix_valid),
      .pix_ready(1'b1), .oled_rst(a_oled_rst), .busy(a_busy),
      .frames_sent(a_frames_sent)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // frame buffer: port A write, port B 1-cycle synchronous read
   always @(posedge clk) begin
      if (cap_we_out) mem[cap_addr] <= cap_data;
      rd_data <= (rd_addr < 13'(C_PXLS)) ? mem[rd_addr] : 16'd0;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL timeout_%s: got no event expected event", nm);
   endtask

   // camera ramp: pixel value = address ^ per-frame xor
   initial begin
      cap_we_in = 1'b0;
      cap_addr  = 13'd0;
      cap_data  = 16'd0;
      forever begin
         @(posedge clk);
         #1;
         if (cap_run) begin
            if (cap_cnt == 13'd0) cap_xor = next_xor;
            cap_we_in = 1'b1;
            cap_addr  = cap_cnt;
            cap_data  = {3'b000, cap_cnt} ^ cap_xor;
            cap_cnt   = (cap_cnt == 13'(C_PXLS - 1)) ? 13'd0 : cap_cnt + 13'd1;
         end else begin
            cap_we_in = 1'b0;
         end
      end
   end

   initial begin
      pix_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         pix_ready = bp_mode ? (cyc % 7 == 0) : ready_level;
      end
   end

   // monitor: pops the scoreboard on every handshake
   logic        stall_prev = 1'b0;
   logic [15:0] stall_data = 16'd0;
   logic        have_last = 1'b0;
   int          last_cyc = 0;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
         have_last  = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_valid", 32'(pix_valid), 32'd1);
            chk("stall_data", 32'(pix_data), 32'(stall_data));
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pixel: got %0d expected none", pix_data);
            end else begin
               logic [15:0] e;
               logic [12:0] a;
               e = exp_q.pop_front();
               a = addr_q.pop_front();
               chk("pix_data", 32'(pix_data), 32'(e));
               chk("stream_rd_addr", 32'(rd_addr), 32'(a));
               chk("stream_vga_blank", 32'(vga_blank), 32'd1);
            end
            if (chk_period && have_last) chk("pixel_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc  = cyc;
            have_last = chk_period;
         end
         stall_prev = pix_valid && !pix_ready;
         stall_data = pix_data;
      end
   end

   task automatic wait_frame_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cap_we_in && cap_addr == 13'd0) && n < 6000);
      if (n >= 6000) timeout("frame_start");
   endtask

   task automatic wait_valid();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!pix_valid && n < 12000);
      if (n >= 12000) timeout("pix_valid");
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < limit);
      if (n >= limit) timeout("idle");
   endtask

   task automatic do_snap(input logic [15:0] x, input bit push);
      next_xor = x;
      wait_frame_start();
      next_xor = ~x;
      snap_req = 1'b1;
      repeat (2) @(negedge clk);
      snap_req = 1'b0;
      if (push) begin
         for (int i = 0; i < C_PXLS; i++) begin
            exp_q.push_back({3'b000, 13'(i)} ^ x);
            addr_q.push_back(13'(i));
         end
      end
   endtask

   // auto-snap instance: 32-pixel frames, 32 writes then 96 idle cycles
   initial begin
      a_rst      = 1'b1;
      a_cap_we   = 1'b0;
      a_cap_addr = 13'd0;
      repeat (3) @(posedge clk);
      #1 a_rst = 1'b0;
      for (int f = 1; f <= 10; f++) begin
         for (int p = 0; p < 128; p++) begin
            @(posedge clk);
            #1;
            a_cap_we   = (p < 32);
            a_cap_addr = (p < 32) ? 13'(p) : 13'd0;
            if (f == 2 && p == 40) chk("auto_no_early_arm", 32'(a_busy), 32'd0);
            if (f == 3 && p == 31) chk("auto_busy_at_eof3", 32'(a_busy), 32'd0);
            if (f == 3 && p == 32) chk("auto_busy_eof3_p1", 32'(a_busy), 32'd0);
            if (f == 3 && p == 33) chk("auto_arm_after_eof3", 32'(a_busy), 32'd1);
            if (f == 5 && p == 64) chk("auto_first_snap", 32'(a_frames_sent), 32'd1);
         end
      end
      chk("auto_two_snaps", 32'(a_frames_sent), 32'd2);
      chk("auto_idle_end", 32'(a_busy), 32'd0);
      auto_done = 1'b1;
   end

   logic [12:0] own_addr [3];

   initial begin
      own_addr[0] = 13'd77;
      own_addr[1] = 13'd4799;
      own_addr[2] = 13'd0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_pix_valid", 32'(pix_valid), 32'd0);
      chk("rst_pix_data", 32'(pix_data), 32'd0);
      chk("rst_oled_rst", 32'(oled_rst), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vga_blank", 32'(vga_blank), 32'd0);
      chk("rst_frames_sent", 32'(frames_sent), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd123);
      rst     = 1'b0;
      cap_run = 1'b1;
      repeat (3) @(negedge clk);
      chk("live_we", 32'(cap_we_out), 32'd1);
      btn_hold = 1'b1;
      #1 chk("hold_we", 32'(cap_we_out), 32'd0);
      @(negedge clk);
      btn_hold = 1'b0;

      // reset while a pixel is held unacknowledged
      ready_level = 1'b0;
      do_snap(16'h0BAD, 1'b0);
      wait_valid();
      repeat (3) @(negedge clk);
      chk("hold_pre_rst_valid", 32'(pix_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_pix_valid", 32'(pix_valid), 32'd0);
      chk("midrst_oled_rst", 32'(oled_rst), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_vga_blank", 32'(vga_blank), 32'd0);
      chk("midrst_frames_sent", 32'(frames_sent), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // manual snap with the sink always ready
      ready_level = 1'b1;
      chk_period  = 1'b1;
      do_snap(16'h0000, 1'b1);
      begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(cap_we_in && cap_addr == 13'd4799) && n < 6000);
         if (n >= 6000) timeout("eof");
      end
      chk("eof_we", 32'(cap_we_out), 32'd1);
      @(negedge clk);
      chk("post_eof_we", 32'(cap_we_out), 32'd0);
      chk("stream_oled_rst", 32'(oled_rst), 32'd0);
      wait_idle(20000);
      chk_period = 1'b0;
      chk("snap1_frames_sent", 32'(frames_sent), 32'd1);
      chk("snap1_busy", 32'(busy), 32'd0);
      chk("snap1_queue_empty", 32'(exp_q.size()), 32'd0);

      // back-pressure plus snap_req toggling mid-stream
      bp_mode = 1'b1;
      do_snap(16'h1234, 1'b1);
      wait_valid();
      for (int k = 0; k < 4; k++) begin
         snap_req = 1'b1;
         repeat (5) @(negedge clk);
         snap_req = 1'b0;
         repeat (5) @(negedge clk);
      end
      wait_idle(45000);
      bp_mode = 1'b0;
      chk("snap2_frames_sent", 32'(frames_sent), 32'd2);
      repeat (20) @(negedge clk);
      chk("no_queued_snap_busy", 32'(busy), 32'd0);
      chk("no_queued_snap_count", 32'(frames_sent), 32'd2);
      chk("snap2_queue_empty", 32'(exp_q.size()), 32'd0);

      // display owns port B in LIVE
      for (int i = 0; i < 3; i++) begin
         vga_addr = own_addr[i];
         #1;
         chk("live_rd_addr", 32'(rd_addr), 32'(own_addr[i]));
         chk("live_vga_blank", 32'(vga_blank), 32'd0);
         chk("live_oled_rst", 32'(oled_rst), 32'd1);
         @(negedge clk);
      end

      begin
         int n = 0;
         while (!auto_done && n < 5000) begin
            @(negedge clk);
            n++;
         end
         if (!auto_done) timeout("auto");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
